// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x oversampling UART receiver for frames of
// start + 8 data bits (LSB first) + parity + 1 stop bit.
// Received bytes are delivered through a valid/ack handshake together with
// parity, stop and sticky overrun flags.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3
// majority of the samples at counts 6, 7 and 8. When it is defined, every
// decision and the commit happen one tick later.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | line idle, waiting for a synchronised low level
// S_START    | start edge seen, confirming start bit at the sample point
// S_DATA     | shifting in 8 data bits, LSB first
// S_PARITY   | sampling the parity bit and computing the parity error
// S_STOP     | sampling the stop bit; commit to the output registers
// S_WAIT     | stop bit was low; wait for the line to return high
module uart_rx_frame #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       stop_error,
  output logic       overrun_error,
  output logic       rx_busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  logic [1:0]       sync_q;
  logic             rx_s;
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  logic [2:0]       state;
  logic [3:0]       sample_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             par_err_q;
  logic             sample_pt;
  logic             bit_val;
  logic             commit;

  // Two-flop synchroniser; preset high so reset looks like an idle line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // Free-running oversampling divider; one-cycle tick when the count expires.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= DIV_TC;
    end else begin
      tick_cnt <= tick_cnt - DIV_W'(1);
    end
  end

  assign tick = (tick_cnt == '0);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q;

  // Capture the two early samples of the majority vote (counts 6 and 7).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      maj_q <= 2'b11;
    end else if (tick && (sample_cnt == 4'd6)) begin
      maj_q[0] <= rx_s;
    end else if (tick && (sample_cnt == 4'd7)) begin
      maj_q[1] <= rx_s;
    end
  end

  assign sample_pt = tick && (sample_cnt == 4'd8);
  assign bit_val   = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
  assign sample_pt = tick && (sample_cnt == 4'd7);
  assign bit_val   = rx_s;
`endif

  // Frame sequencer: sample counting, bit shifting and parity evaluation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      sample_cnt <= 4'd0;
      bit_cnt    <= 3'd0;
      shift_q    <= 8'd0;
      par_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sample_cnt <= 4'd0;
          bit_cnt    <= 3'd0;
          if (!rx_s) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
          end
          if (sample_pt) begin
            // A high level here was only a glitch: drop it silently.
            state <= bit_val ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
          end
          if (sample_pt) begin
            shift_q <= {bit_val, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
          end
          if (sample_pt) begin
            par_err_q <= (^shift_q) ^ bit_val ^ ODD_BIT;
            state     <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
          end
          if (sample_pt) begin
            // A low stop bit may be a held-low line; wait for high before rearming.
            state <= bit_val ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          sample_cnt <= 4'd0;
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          sample_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign commit = (state == S_STOP) && sample_pt;

  // Output registers and handshake; a commit takes priority over an ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_data       <= 8'd0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      stop_error    <= 1'b0;
      overrun_error <= 1'b0;
    end else if (commit) begin
      rx_data      <= shift_q;
      parity_error <= par_err_q;
      stop_error   <= ~bit_val;
      rx_valid     <= 1'b1;
      if (rx_valid && !rx_ack) begin
        overrun_error <= 1'b1;
      end
    end else if (rx_valid && rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

  assign rx_busy = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: drives serial frames into an even-parity and an
// odd-parity receiver sharing one line and compares both against a
// frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 250_000;
  localparam int BIT_CLKS = 64;
`ifdef UART_RX_MAJORITY_EN
  localparam int ACK_LEAD = 675;
`else
  localparam int ACK_LEAD = 671;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            rx    = 1'b1;
  logic [1:0]      ack   = 2'b00;
  logic [1:0][7:0] rx_data_v;
  logic [1:0]      rx_valid_v;
  logic [1:0]      perr_v;
  logic [1:0]      serr_v;
  logic [1:0]      ovr_v;
  logic [1:0]      rx_busy_v;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_data;
  logic [1:0] m_valid;
  logic [1:0] m_perr;
  logic       m_serr;
  logic [1:0] m_ovr;

  always #5 clock = ~clock;

  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_ODD(0)) dut_even (
    .clock(clock), .reset(reset), .rx(rx), .rx_ack(ack[0]),
    .rx_data(rx_data_v[0]), .rx_valid(rx_valid_v[0]), .parity_error(perr_v[0]),
    .stop_error(serr_v[0]), .overrun_error(ovr_v[0]), .rx_busy(rx_busy_v[0])
  );

  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_ODD(1)) dut_odd (
    .clock(clock), .reset(reset), .rx(rx), .rx_ack(ack[1]),
    .rx_data(rx_data_v[1]), .rx_valid(rx_valid_v[1]), .parity_error(perr_v[1]),
    .stop_error(serr_v[1]), .overrun_error(ovr_v[1]), .rx_busy(rx_busy_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    wait_clks(n);
  endtask

  task automatic model_reset();
    m_data  = 8'd0;
    m_valid = 2'b00;
    m_perr  = 2'b00;
    m_serr  = 1'b0;
    m_ovr   = 2'b00;
  endtask

  // Frame-level view: a complete frame replaces the held byte; an unacked
  // held byte becomes an overrun unless the ack coincides with the new byte.
  task automatic model_commit(input logic [7:0] d, input logic p, input logic s,
                              input logic ack_same);
    int ones;
    ones = $countones(d) + int'(p);
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i] && !ack_same) m_ovr[i] = 1'b1;
      m_valid[i] = 1'b1;
      m_perr[i]  = ((ones % 2) != i);
    end
    m_data = d;
    m_serr = !s;
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.data%0d", tag, i),  rx_data_v[i],  m_data);
      chk($sformatf("%s.valid%0d", tag, i), rx_valid_v[i], m_valid[i]);
      chk($sformatf("%s.perr%0d", tag, i),  perr_v[i],     m_perr[i]);
      chk($sformatf("%s.serr%0d", tag, i),  serr_v[i],     m_serr);
      chk($sformatf("%s.ovr%0d", tag, i),   ovr_v[i],      m_ovr[i]);
      chk($sformatf("%s.busy%0d", tag, i),  rx_busy_v[i],  1'b0);
    end
  endtask

  task automatic pulse_ack(input string tag);
    ack = 2'b11;
    wait_clks(1);
    ack = 2'b00;
    m_valid = 2'b00;
    chk({tag, ".ack_drop"}, rx_valid_v, 2'b00);
  endtask

  // Full frame; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        drive_bit(d[i], BIT_CLKS / 2);
        chk("busy_mid", rx_busy_v, 2'b11);
        wait_clks(BIT_CLKS / 2);
      end else begin
        drive_bit(d[i], BIT_CLKS);
      end
    end
    drive_bit(p, BIT_CLKS);
    drive_bit(s, BIT_CLKS);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [1:0] busy_seen;

    model_reset();
    wait_clks(5);
    check_outputs("reset");
    reset = 1'b1;
    wait_clks(20);

    // Clean frame, then handshake.
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_clks(16);
    model_commit(8'hA5, 1'b0, 1'b1, 1'b0);
    check_outputs("a5");
    pulse_ack("a5");

    // Parity bit set: wrong for even mode, right for odd mode.
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_clks(16);
    model_commit(8'h3C, 1'b1, 1'b1, 1'b0);
    check_outputs("3c");
    pulse_ack("3c");

    // Low stop bit with the line held low afterwards.
    send_frame(8'h55, 1'b0, 1'b0);
    drive_bit(1'b0, 200);
    model_commit(8'h55, 1'b0, 1'b0, 1'b0);
    check_outputs("55_stop");
    pulse_ack("55_stop");
    drive_bit(1'b0, 50);
    check_outputs("55_held");
    drive_bit(1'b1, 80);
    check_outputs("55_release");

    // Short low glitch must not start a frame.
    busy_seen = 2'b00;
    drive_bit(1'b0, 20);
    rx = 1'b1;
    for (int c = 0; c < 120; c++) begin
      wait_clks(1);
      busy_seen = busy_seen | rx_busy_v;
    end
    chk("glitch_busy", busy_seen, 2'b00);
    check_outputs("glitch");

    // Randomised frames, random errors, random acks.
    for (int f = 0; f < 10; f++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s);
      if (!s) drive_bit(1'b0, 100);
      drive_bit(1'b1, $urandom_range(8, 80));
      model_commit(d, p, s, 1'b0);
      check_outputs($sformatf("rnd%0d", f));
      if ($urandom_range(0, 1) == 1) pulse_ack($sformatf("rnd%0d", f));
    end

    // Reset in the middle of the data bits of 0xF0.
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b0, 30);
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.valid", rx_valid_v, 2'b00);
    chk("rst_mid.ovr",   ovr_v,      2'b00);
    chk("rst_mid.busy",  rx_busy_v,  2'b00);
    chk("rst_mid.data",  rx_data_v,  16'h0000);
    rx = 1'b1;
    wait_clks(5);
    reset = 1'b1;
    wait_clks(BIT_CLKS);
    send_frame(8'h0F, 1'b0, 1'b1);
    wait_clks(16);
    model_commit(8'h0F, 1'b0, 1'b1, 1'b0);
    check_outputs("0f");
    pulse_ack("0f");

    // Back-to-back frames without ack: overrun.
    send_frame(8'h11, 1'b0, 1'b1);
    model_commit(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);
    model_commit(8'h22, 1'b0, 1'b1, 1'b0);
    wait_clks(16);
    check_outputs("overrun");

    // Same pair with the ack landing on the second commit: no overrun.
    reset = 1'b0;
    wait_clks(3);
    model_reset();
    reset = 1'b1;
    wait_clks(10);
    send_frame(8'h11, 1'b0, 1'b1);
    model_commit(8'h11, 1'b0, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b0, 1'b1);
      begin
        wait_clks(ACK_LEAD);
        ack = 2'b11;
        wait_clks(1);
        ack = 2'b00;
      end
    join
    model_commit(8'h22, 1'b0, 1'b1, 1'b1);
    wait_clks(16);
    check_outputs("ack_commit");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
